// File: rtl/tt_scan_pkg.sv
// ============================================================================
// Module : tt_scan_pkg
// Shared types and constants for the truth-table scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  localparam logic [N_VEC-1:0] DEFAULT_EXPECTED_TABLE = 16'h4644;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module : settle_timer
// Counts hold cycles for one stimulus vector; tc marks the sample cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE_CYCLES);

  logic [3:0] cnt_q, cnt_d;

  assign tc = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// Module : truth_table_scanner
// Walks p,q,r,s through all 16 vectors, captures t_in into a truth table and
// counts maxterms. Optional golden compare enabled by GOLDEN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int               SETTLE_CYCLES  = 1,
  parameter logic [N_VEC-1:0] EXPECTED_TABLE = DEFAULT_EXPECTED_TABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             t_in,
  output logic             p,
  output logic             q,
  output logic             r,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic [CNT_W-1:0] zero_count
`ifdef GOLDEN_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   vec_q, vec_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [CNT_W-1:0]   zc_q, zc_d;
  logic               tmr_clear, tmr_en, tmr_tc, sample;
`ifdef GOLDEN_CHECK_EN
  logic               mismatch_q, mismatch_d;
`endif

  // The first DRIVE cycle only loads the stimulus flops; the settle window
  // opens after it, which gives the 16*(SETTLE_CYCLES+1)+1 start-to-done delay.
  assign sample    = (state_q == DRIVE) && armed_q && tmr_tc;
  assign tmr_en    = (state_q == DRIVE);
  assign tmr_clear = (state_q != DRIVE) || !armed_q || sample;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .enable(tmr_en),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    table_d = table_q;
    zc_d    = zc_q;
`ifdef GOLDEN_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          armed_d = 1'b0;
          table_d = '0;
          zc_d    = '0;
`ifdef GOLDEN_CHECK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      DRIVE: begin
        armed_d = 1'b1;
        if (sample) begin
          table_d[idx_q] = t_in;
          if (!t_in) begin
            zc_d = zc_q + 5'd1;
          end
          if (idx_q == IDX_W'(N_VEC - 1)) begin
            state_d = DONE;
`ifdef GOLDEN_CHECK_EN
            mismatch_d = (table_d != EXPECTED_TABLE);
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    vec_d  = (state_d == DRIVE) ? idx_d : '0;
    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      zc_q    <= '0;
`ifdef GOLDEN_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      zc_q    <= zc_d;
`ifdef GOLDEN_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign {p, q, r, s} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign zero_count   = zc_q;
`ifdef GOLDEN_CHECK_EN
  assign mismatch     = mismatch_q;
`endif

endmodule

`default_nettype wire

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/response engine for the 4-input, 1-output combinational lab functions t = f(p,q,r,s).
- Drives all 16 input vectors p,q,r,s into a function under test, samples its t output and assembles the 16-bit truth table.
- Counts the zero entries (maxterms) so the count can be checked against the hand-derived SoP/PoS forms.
- Sits in the lab test harness, on the opposite side of the p/q/r/s/t interface from the function block.

Parameters:
- SETTLE_CYCLES, 1, extra idle cycles each vector is held before t_in is sampled; legal range 0..15.
- EXPECTED_TABLE, 16'h4644, golden truth table. Bit i holds t for index i = {p,q,r,s}. Used only with GOLDEN_CHECK_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- t_in  in  1  output of the function under test.
- p  out  1  stimulus MSB, idx[3].
- q  out  1  stimulus, idx[2].
- r  out  1  stimulus, idx[1].
- s  out  1  stimulus LSB, idx[0].
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the scan completes.
- table_out  out  16  captured truth table; bit i = t_in sampled at index i.
- zero_count  out  5  number of 0 entries, range 0..16.
- mismatch  out  1  present only with GOLDEN_CHECK_EN; table_out != EXPECTED_TABLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, state IDLE, idx 0, settle counter 0, mismatch 0.
- State IDLE:
  - p,q,r,s = 0000; busy = 0.
  - start = 1 → DRIVE. On that edge: idx = 0, settle counter = 0, table_out = 0, zero_count = 0, busy = 1.
- State DRIVE:
  - {p,q,r,s} = idx, registered, so the outputs are glitch-free.
  - Each vector is held for SETTLE_CYCLES+1 cycles. t_in is sampled on the last edge of that window.
  - At the sample edge: table_out[idx] = t_in; zero_count increments if t_in = 0.
  - If idx < 15: idx increments and the settle counter clears.
  - If idx = 15: → DONE.
- State DONE:
  - Lasts one cycle: done = 1, busy = 0, p,q,r,s = 0000.
  - Then → IDLE unconditionally.
- Latency: done is high in the cycle that starts 16*(SETTLE_CYCLES+1)+1 edges after the start edge. With the default SETTLE_CYCLES = 1 that is 33 edges.
- Holding results: table_out and zero_count hold their values after DONE until the next accepted start.
- start while busy or in DONE: ignored, not queued.
- Reset mid-scan: immediate return to reset values; the partial table is discarded.
- zero_count width: 5 bits so the all-zero function (16) does not overflow. idx is 4 bits and stops at 15, never wrapping.

Optional Feature:
- Macro: GOLDEN_CHECK_EN.
- When defined:
  - The mismatch port exists.
  - mismatch is registered and is updated on the DONE transition as (table_out_final != EXPECTED_TABLE).
  - mismatch holds until the next start, which clears it, or until reset.
- When undefined: no mismatch port, no comparator logic, and EXPECTED_TABLE is unused.

Decomposition:
- Package tt_scan_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - N_VEC = 16, IDX_W = 4, CNT_W = 5;
  - default EXPECTED_TABLE constant 16'h4644.
- Sub-module settle_timer:
  - clear/enable inputs, a terminal-count output at SETTLE_CYCLES;
  - instantiated once in truth_table_scanner.

Test Plan:
- Hand-minimised PoS model (p+r)(r'+s')(p'+r+s)(p'+q'+r) on t_in, SETTLE_CYCLES = 1, start pulse → done at edge 33, table_out = 16'h4644, zero_count = 11, mismatch = 0.
- t_in tied 0, then tied 1 → table_out = 16'h0000 with zero_count = 16, then 16'hFFFF with zero_count = 0. Verifies zero_count does not overflow.
- start re-pulsed at edges 5 and 20 of a scan → ignored; done pulses once at edge 33; busy stays high throughout.
- rst_n low at edge 12 of a scan → all outputs 0 immediately; next start gives a clean, correct scan.
- XOR model t = p^q^r^s with GOLDEN_CHECK_EN → table_out = 16'h6996, zero_count = 8, mismatch = 1. Next start clears mismatch.
- SETTLE_CYCLES = 0 and SETTLE_CYCLES = 3 with the golden model → done at edges 17 and 65; table_out = 16'h4644 in both.
